// File: rtl/vmode_switch_ctrl.sv
// Video-mode switch controller: validates a requested mode, waits for a frame boundary, then
// applies it while holding the timing generator in reset. Build macro VMODE_TIMEOUT_EN adds a frame-wait timeout.
module vmode_switch_ctrl #(
    parameter int unsigned        HW         = 12,
    parameter int unsigned        VW         = 12,
    parameter int unsigned        RST_CYCLES = 4,
    parameter int unsigned        MIN_ACTIVE = 16,
    parameter logic [4*HW-1:0]    DEF_HMODE  = {HW'(640), HW'(656), HW'(752), HW'(800)},
    parameter logic [4*VW-1:0]    DEF_VMODE  = {VW'(480), VW'(490), VW'(492), VW'(525)},
    parameter int unsigned        TIMEOUT    = 2000000
) (
    input  logic          i_pixclk,
    input  logic          i_reset_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [HW-1:0] i_hm_width,
    input  logic [HW-1:0] i_hm_porch,
    input  logic [HW-1:0] i_hm_synch,
    input  logic [HW-1:0] i_hm_raw,
    input  logic [VW-1:0] i_vm_height,
    input  logic [VW-1:0] i_vm_porch,
    input  logic [VW-1:0] i_vm_synch,
    input  logic [VW-1:0] i_vm_raw,
    input  logic          i_newframe,
    output logic          o_tg_reset,
    output logic [HW-1:0] o_hm_width,
    output logic [HW-1:0] o_hm_porch,
    output logic [HW-1:0] o_hm_synch,
    output logic [HW-1:0] o_hm_raw,
    output logic [VW-1:0] o_vm_height,
    output logic [VW-1:0] o_vm_porch,
    output logic [VW-1:0] o_vm_synch,
    output logic [VW-1:0] o_vm_raw,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [1:0] {StIdle, StCheck, StWait, StHold} state_e;

    localparam int unsigned   CW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("vmode_switch_ctrl: RST_CYCLES and TIMEOUT must be at least 1");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sw_q, sw_d;  // current HOLD phase belongs to a requested switch
    logic [4*HW-1:0] sh_h_q, sh_h_d, hm_q, hm_d;
    logic [4*VW-1:0] sh_v_q, sh_v_d, vm_q, vm_d;
    logic            tg_q, tg_d, ready_q, busy_q, done_q, done_d, err_q, err_d;
    logic            mode_ok, frame_go;

    assign mode_ok =
        (sh_h_q[4*HW-1 -: HW] > HW'(MIN_ACTIVE)) &&
        (sh_h_q[4*HW-1 -: HW] < sh_h_q[3*HW-1 -: HW]) &&
        (sh_h_q[3*HW-1 -: HW] < sh_h_q[2*HW-1 -: HW]) &&
        (sh_h_q[2*HW-1 -: HW] < sh_h_q[HW-1:0]) &&
        (sh_v_q[4*VW-1 -: VW] > VW'(MIN_ACTIVE)) &&
        (sh_v_q[4*VW-1 -: VW] < sh_v_q[3*VW-1 -: VW]) &&
        (sh_v_q[3*VW-1 -: VW] < sh_v_q[2*VW-1 -: VW]) &&
        (sh_v_q[2*VW-1 -: VW] < sh_v_q[VW-1:0]);

`ifdef VMODE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q;

    // Counts cycles spent in WAIT; held at zero everywhere else.
    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n || state_q != StWait) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TW'(1);
        end
    end

    assign frame_go = i_newframe || (tmr_q == TW'(TIMEOUT - 1));
`else
    assign frame_go = i_newframe;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        sh_h_d  = sh_h_q;
        sh_v_d  = sh_v_q;
        hm_d    = hm_q;
        vm_d    = vm_q;
        tg_d    = tg_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid && ready_q) begin
                    sh_h_d  = {i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw};
                    sh_v_d  = {i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw};
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mode_ok) begin
                    state_d = StWait;
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (frame_go) begin
                    hm_d    = sh_h_q;
                    vm_d    = sh_v_q;
                    tg_d    = 1'b1;
                    cnt_d   = CntLoad;
                    sw_d    = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    tg_d    = 1'b0;
                    done_d  = sw_q;
                    sw_d    = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            state_q <= StHold;
            cnt_q   <= CntLoad;
            sw_q    <= 1'b0;
            sh_h_q  <= '0;
            sh_v_q  <= '0;
            hm_q    <= DEF_HMODE;
            vm_q    <= DEF_VMODE;
            tg_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            sh_h_q  <= sh_h_d;
            sh_v_q  <= sh_v_d;
            hm_q    <= hm_d;
            vm_q    <= vm_d;
            tg_q    <= tg_d;
            ready_q <= (state_d == StIdle);
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_tg_reset  = tg_q;
    assign o_hm_width  = hm_q[4*HW-1 -: HW];
    assign o_hm_porch  = hm_q[3*HW-1 -: HW];
    assign o_hm_synch  = hm_q[2*HW-1 -: HW];
    assign o_hm_raw    = hm_q[HW-1:0];
    assign o_vm_height = vm_q[4*VW-1 -: VW];
    assign o_vm_porch  = vm_q[3*VW-1 -: VW];
    assign o_vm_synch  = vm_q[2*VW-1 -: VW];
    assign o_vm_raw    = vm_q[VW-1:0];

endmodule

// File: tb/tb_vmode_switch_ctrl.sv
// Randomized self-checking bench for vmode_switch_ctrl against a transaction-level model of
// mode validation, frame-boundary application and reset-hold timing.
module tb_vmode_switch_ctrl;

    localparam int unsigned RST = 4;
    localparam int unsigned TO  = 100;
    localparam logic [47:0] DEF_H = {12'd640, 12'd656, 12'd752, 12'd800};
    localparam logic [47:0] DEF_V = {12'd480, 12'd490, 12'd492, 12'd525};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, newframe, tg_reset, busy, done, err;
    logic [11:0] i_hw, i_hp, i_hs, i_hr, i_vh, i_vp, i_vs, i_vr;
    logic [11:0] hm_width, hm_porch, hm_synch, hm_raw, vm_height, vm_porch, vm_synch, vm_raw;
    logic [47:0] obs_h, obs_v;

    assign obs_h = {hm_width, hm_porch, hm_synch, hm_raw};
    assign obs_v = {vm_height, vm_porch, vm_synch, vm_raw};

    vmode_switch_ctrl #(
        .HW(12), .VW(12), .RST_CYCLES(RST), .MIN_ACTIVE(16), .TIMEOUT(TO)
    ) dut (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_hm_width(i_hw), .i_hm_porch(i_hp), .i_hm_synch(i_hs), .i_hm_raw(i_hr),
        .i_vm_height(i_vh), .i_vm_porch(i_vp), .i_vm_synch(i_vs), .i_vm_raw(i_vr),
        .i_newframe(newframe), .o_tg_reset(tg_reset),
        .o_hm_width(hm_width), .o_hm_porch(hm_porch), .o_hm_synch(hm_synch), .o_hm_raw(hm_raw),
        .o_vm_height(vm_height), .o_vm_porch(vm_porch), .o_vm_synch(vm_synch), .o_vm_raw(vm_raw),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    int checks = 0;
    int failures = 0;
    logic [47:0] exp_h, exp_v;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fields_ok(input logic [47:0] m);
        int a, b, c, d;
        a = int'(m[47:36]);
        b = int'(m[35:24]);
        c = int'(m[23:12]);
        d = int'(m[11:0]);
        return (a > 16) && (a < b) && (b < c) && (c < d);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_fields(input logic [47:0] h, input logic [47:0] v);
        {i_hw, i_hp, i_hs, i_hr} = h;
        {i_vh, i_vp, i_vs, i_vr} = v;
    endtask

    task automatic gen_mode(output logic [47:0] m);
        int w, p, s, r;
        w = $urandom_range(10, 900);
        p = w + $urandom_range(0, 25);
        s = p + $urandom_range(0, 25);
        r = s + $urandom_range(0, 25);
        m = {12'(w), 12'(p), 12'(s), 12'(r)};
    endtask

    // Counts cycles with tg_reset high, then checks the release cycle.
    task automatic hold_phase(input bit exp_done, input string tag);
        int n = 0;
        while (tg_reset === 1'b1 && n < 50) begin
            check_eq({tag, "_hold_mode_h"}, obs_h, exp_h);
            check_eq({tag, "_hold_mode_v"}, obs_v, exp_v);
            check_eq({tag, "_hold_done"}, done, 0);
            newframe = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        newframe  = 1'b0;
        req_valid = 1'b0;
        check_eq({tag, "_tg_len"}, n, RST);
        check_eq({tag, "_done_at_fall"}, done, exp_done);
        check_eq({tag, "_ready_at_fall"}, req_ready, 1);
        check_eq({tag, "_busy_at_fall"}, busy, 0);
        check_eq({tag, "_err_at_fall"}, err, 0);
        step();
        check_eq({tag, "_done_after"}, done, 0);
        check_eq({tag, "_tg_after"}, tg_reset, 0);
        check_eq({tag, "_ready_after"}, req_ready, 1);
    endtask

    task automatic reset_seq(input int n);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        newframe  = 1'b0;
        repeat (n) step();
        exp_h = DEF_H;
        exp_v = DEF_V;
        check_eq("rst_tg", tg_reset, 1);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_mode_h", obs_h, DEF_H);
        check_eq("rst_mode_v", obs_v, DEF_V);
        rst_n = 1'b1;
        hold_phase(1'b0, "pwr");
    endtask

    task automatic idle_noise(input int n);
        logic [47:0] g;
        repeat (n) begin
            req_valid = 1'b0;
            newframe  = 1'($urandom_range(0, 1));
            gen_mode(g);
            drive_fields(g, ~g);
            step();
            check_eq("idle_ready", req_ready, 1);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_tg", tg_reset, 0);
            check_eq("idle_mode_h", obs_h, exp_h);
            check_eq("idle_mode_v", obs_v, exp_v);
        end
        newframe = 1'b0;
    endtask

    // abort: 0 none, 1 reset during WAIT, 2 reset during HOLD; nf_delay < 0 means no newframe.
    task automatic do_req(input logic [47:0] h, input logic [47:0] v, input int nf_delay,
                          input bit noise, input int abort);
        bit ok;
        int k;
        logic [47:0] g;
        ok = fields_ok(h) && fields_ok(v);
        drive_fields(h, v);
        req_valid = 1'b1;
        check_eq("req_ready_before", req_ready, 1);
        step();
        gen_mode(g);
        drive_fields(g, g);
        newframe = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        check_eq("chk_busy", busy, 1);
        check_eq("chk_ready", req_ready, 0);
        check_eq("chk_err", err, 0);
        step();
        newframe = 1'b0;
        if (!ok) begin
            req_valid = 1'b0;
            check_eq("rej_err", err, 1);
            check_eq("rej_tg", tg_reset, 0);
            check_eq("rej_done", done, 0);
            check_eq("rej_mode_h", obs_h, exp_h);
            check_eq("rej_mode_v", obs_v, exp_v);
            step();
            check_eq("rej_err_after", err, 0);
            check_eq("rej_busy_after", busy, 0);
            return;
        end
        check_eq("acc_err", err, 0);
        check_eq("acc_ready", req_ready, 0);
        req_valid = noise;
        k = 0;
        while (tg_reset !== 1'b1 && k < 300) begin
            check_eq("wait_mode_h", obs_h, exp_h);
            check_eq("wait_mode_v", obs_v, exp_v);
            check_eq("wait_done", done, 0);
            if (abort == 1 && k == 3) begin
                reset_seq(1);
                return;
            end
            newframe = (k == nf_delay);
            if (noise) begin
                gen_mode(g);
                drive_fields(g, ~g);
            end
            step();
            k++;
        end
        newframe = 1'b0;
        check_eq("switch_latency", k, (nf_delay >= 0) ? nf_delay + 1 : int'(TO));
        exp_h = h;
        exp_v = v;
        check_eq("applied_h", obs_h, h);
        check_eq("applied_v", obs_v, v);
        if (abort == 2) begin
            step();
            reset_seq(1);
            return;
        end
        hold_phase(1'b1, "sw");
    endtask

    initial begin
        logic [47:0] rh, rv;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        newframe  = 1'b0;
        drive_fields('0, '0);
        exp_h = DEF_H;
        exp_v = DEF_V;
        step();
        reset_seq(3);
        idle_noise(5);
        do_req({12'd800, 12'd840, 12'd968, 12'd1056}, {12'd600, 12'd601, 12'd605, 12'd628},
               50, 1'b0, 0);
        idle_noise(3);
        do_req({12'd16, 12'd840, 12'd968, 12'd1056}, {12'd600, 12'd601, 12'd605, 12'd628},
               5, 1'b0, 0);
        do_req({12'd800, 12'd968, 12'd968, 12'd1056}, {12'd600, 12'd601, 12'd605, 12'd628},
               5, 1'b1, 0);
        do_req({12'd800, 12'd840, 12'd968, 12'd1056}, {12'd600, 12'd601, 12'd605, 12'd601},
               5, 1'b0, 0);
        do_req(DEF_H, DEF_V, 0, 1'b1, 0);
        for (int i = 0; i < 14; i++) begin
            gen_mode(rh);
            gen_mode(rv);
            do_req(rh, rv, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 0);
            idle_noise($urandom_range(1, 4));
        end
        do_req({12'd800, 12'd840, 12'd968, 12'd1056}, {12'd600, 12'd601, 12'd605, 12'd628},
               10, 1'b1, 1);
        idle_noise(6);
        do_req({12'd1024, 12'd1048, 12'd1184, 12'd1344}, {12'd768, 12'd771, 12'd777, 12'd806},
               5, 1'b1, 2);
        idle_noise(6);
`ifdef VMODE_TIMEOUT_EN
        do_req({12'd800, 12'd840, 12'd968, 12'd1056}, {12'd600, 12'd601, 12'd605, 12'd628},
               -1, 1'b0, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vmode_switch_ctrl.md
Name: vmode_switch_ctrl

Overview:
- Controller that owns the video-mode timing registers feeding the low-level VGA timing generator and sequences mode changes safely.
- Accepts a new horizontal/vertical mode via valid/ready handshake and validates ordering.
- Waits for the frame boundary, then holds the timing generator in reset while the new mode is applied, and finally releases it.
- Sits between the register/bus interface and the timing generator; all outputs are registered.

Parameters:
- HW, 12, width of horizontal mode fields
- VW, 12, width of vertical mode fields
- RST_CYCLES, 4, cycles o_tg_reset is held per switch (>=1)
- MIN_ACTIVE, 16, active width/height must be strictly greater than this
- DEF_HMODE, {640,656,752,800}, power-up {width,porch,synch,raw}
- DEF_VMODE, {480,490,492,525}, power-up {height,porch,synch,raw}
- TIMEOUT, 2000000, frame-wait timeout in cycles (used only with VMODE_TIMEOUT_EN)

Ports:
- i_pixclk  in  1  pixel clock; single clock domain
- i_reset_n  in  1  synchronous reset, active-low
- i_req_valid  in  1  new-mode request valid
- o_req_ready  out  1  high only in IDLE
- i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw  in  HW each  requested horizontal mode
- i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw  in  VW each  requested vertical mode
- i_newframe  in  1  new-frame pulse from the timing generator
- o_tg_reset  out  1  active-high reset to the timing generator
- o_hm_width, o_hm_porch, o_hm_synch, o_hm_raw  out  HW each  applied horizontal mode
- o_vm_height, o_vm_porch, o_vm_synch, o_vm_raw  out  VW each  applied vertical mode
- o_busy  out  1  high in any state but IDLE
- o_done  out  1  one-cycle pulse when a switch completes
- o_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - state=HOLD; hold counter=RST_CYCLES-1.
  - o_hm_*/o_vm_* = DEF_HMODE/DEF_VMODE.
  - o_tg_reset=1, o_req_ready=0, o_busy=1, o_done=0, o_err=0.
  - Shadow registers cleared.
  - Reset overrides any state, including mid-switch; a pending request is discarded.
- States: IDLE, CHECK, WAIT, HOLD.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid && o_req_ready, latch all eight inputs into shadow registers and go to CHECK.
  - Inputs are ignored without the handshake.
- CHECK (exactly 1 cycle):
  - Valid iff width>MIN_ACTIVE, width<porch<synch<raw, height>MIN_ACTIVE, and height<porch<synch<raw.
  - Compares are unsigned at field width.
  - Fail: pulse o_err next cycle, return to IDLE, applied mode unchanged.
  - Pass: go to WAIT.
- WAIT:
  - Go to HOLD on the first cycle i_newframe=1.
  - On that transition, copy shadow to o_hm_*/o_vm_*, assert o_tg_reset, and load the counter with RST_CYCLES-1.
  - i_newframe is ignored in all other states.
- HOLD:
  - o_tg_reset=1; counter decrements each cycle.
  - When the counter is 0: o_tg_reset<=0, o_done<=1 (one cycle; only after a switch, never after power-up reset), state<=IDLE.
  - o_tg_reset is therefore high for exactly RST_CYCLES cycles.
- Applied mode outputs change only on WAIT->HOLD (or reset). They never change while o_tg_reset=0.
- Latency: handshake edge to o_tg_reset rising = 2 cycles + wait for i_newframe. o_done follows the o_tg_reset fall on the same edge.
- After reset: o_tg_reset is high for RST_CYCLES cycles, then IDLE with o_done=0.
- o_done and o_err are never high simultaneously.
- A new request cannot be accepted until IDLE is re-entered (ready low during CHECK/WAIT/HOLD).

Optional Feature:
- Macro: VMODE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse without i_newframe, the controller takes the WAIT->HOLD transition anyway and applies the mode normally. This covers a timing generator stalled in reset or a bad prior mode.
  - The counter clears on entering WAIT.
- Undefined: no counter; WAIT lasts until i_newframe.

Test Plan:
- Reset -> release i_reset_n: o_tg_reset high exactly 4 cycles; outputs 640/656/752/800 and 480/490/492/525; o_done stays 0; then o_req_ready=1.
- Valid request {800,840,968,1056}/{600,601,605,628}, i_newframe 50 cycles later -> outputs unchanged until the newframe cycle, then updated; o_tg_reset high 4 cycles; o_done one pulse; ready returns.
- Request with width=16, or porch==synch -> o_err single pulse 2 cycles after handshake; outputs and o_tg_reset unchanged; no wait for i_newframe.
- i_newframe pulses while IDLE/CHECK and i_req_valid held during WAIT/HOLD -> no effect; exactly one switch per accepted handshake.
- i_reset_n asserted during WAIT and during HOLD -> defaults restored, power-up HOLD sequence, shadow request dropped, no o_done.
- VMODE_TIMEOUT_EN with TIMEOUT=100, no i_newframe -> o_tg_reset rises 100 cycles after entering WAIT; mode applied; o_done pulses.
